// File: rtl/iq_gen_hls_deadlock_param_monitor_if.sv
// Monitor-side bundle for the IQ-generator deadlock monitor: block indicators in,
// filtered flag, blocked-stream report and statistics out.
interface iq_gen_hls_deadlock_param_monitor_if #(
    parameter int NUM_AXIS = 4,
    parameter int NUM_SUB  = 2,
    parameter int CNT_W    = 32
);
    localparam int IDX_W = $clog2(NUM_AXIS + 1);

    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_SUB-1:0]  sub_block_sigs;
    logic [NUM_SUB-1:0]  inst_idle_sigs;
    logic                clear;

    logic [NUM_AXIS-1:0] axis_block_info;
    logic [IDX_W-1:0]    first_block_idx;
    logic                block;
    logic [CNT_W-1:0]    block_cycles;
    logic [7:0]          block_events;

    modport master (
        output axis_block_sigs, sub_block_sigs, inst_idle_sigs, clear,
        input  axis_block_info, first_block_idx, block, block_cycles, block_events
    );

    modport slave (
        input  axis_block_sigs, sub_block_sigs, inst_idle_sigs, clear,
        output axis_block_info, first_block_idx, block, block_cycles, block_events
    );
endinterface

// File: rtl/iq_gen_hls_deadlock_param_monitor.sv
// Multi-channel deadlock monitor: filters the raw block condition over HOLD_CYCLES
// consecutive cycles, reports blocked streams and keeps saturating statistics.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no raw block seen last cycle, persistence count at zero
//   PEND    | raw block present, still qualifying toward HOLD_CYCLES
//   BLOCKED | qualified deadlock, block output asserted
module iq_gen_hls_deadlock_param_monitor #(
    parameter int NUM_AXIS    = 4,
    parameter int NUM_SUB     = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 32,
    parameter int STICKY      = 0
) (
    input  logic clock,
    input  logic reset,
    iq_gen_hls_deadlock_param_monitor_if.slave mon
);
    localparam int          IDX_W = $clog2(NUM_AXIS + 1);
    localparam logic [15:0] HOLD  = 16'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, PEND, BLOCKED} state_t;

    state_t              state, state_nxt;
    logic [15:0]         pc;
    logic [NUM_SUB-1:0]  sub_live;
    logic                raw;
    logic                entry;
    logic [IDX_W-1:0]    penc;
    logic [NUM_AXIS-1:0] info_q, info_nxt;
    logic [IDX_W-1:0]    fidx_q;
    logic                block_q;
    logic [CNT_W-1:0]    cyc_q;
    logic [7:0]          ev_q;

    // An idle child cannot be the cause of a deadlock.
    assign sub_live = mon.sub_block_sigs & ~mon.inst_idle_sigs;
    assign raw      = (|mon.axis_block_sigs) | (|sub_live);

    always_comb begin
        penc = IDX_W'(NUM_AXIS);
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (mon.axis_block_sigs[i]) penc = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (raw) state_nxt = (HOLD_CYCLES > 1) ? PEND : BLOCKED;
            end
            PEND: begin
                if (!raw)                      state_nxt = IDLE;
                else if (pc + 16'd1 == HOLD)   state_nxt = BLOCKED;
            end
            BLOCKED: begin
                if (STICKY == 0 && !raw) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (mon.clear) state_nxt = IDLE;
    end

    assign entry = (state != BLOCKED) && (state_nxt == BLOCKED);

    // Sticky mode accumulates every stream seen during the episode.
    always_comb begin
        info_nxt = '0;
        if (state_nxt == BLOCKED) begin
            if (entry || STICKY == 0) info_nxt = mon.axis_block_sigs;
            else                      info_nxt = info_q | mon.axis_block_sigs;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            block_q <= 1'b0;
            info_q  <= '0;
            fidx_q  <= '0;
            cyc_q   <= '0;
            ev_q    <= '0;
        end else begin
            state   <= state_nxt;
            block_q <= (state_nxt == BLOCKED);
            info_q  <= info_nxt;

            // Cleared with the FSM so qualification restarts from zero after clear.
            if (mon.clear || !raw) pc <= '0;
            else if (pc != HOLD)   pc <= pc + 16'd1;

            if (mon.clear)  fidx_q <= '0;
            else if (entry) fidx_q <= penc;

            if (mon.clear)               cyc_q <= '0;
            else if (block_q && ~&cyc_q) cyc_q <= cyc_q + 1'b1;

            if (mon.clear)                   ev_q <= '0;
            else if (entry && ev_q != 8'hFF) ev_q <= ev_q + 8'd1;
        end
    end

    assign mon.block           = block_q;
    assign mon.axis_block_info = block_q ? info_q : '0;
    assign mon.first_block_idx = fidx_q;
    assign mon.block_cycles    = cyc_q;
    assign mon.block_events    = ev_q;
endmodule

// File: tb/tb_iq_gen_hls_deadlock_param_monitor.sv
// Bench for the deadlock monitor: three configurations share one stimulus stream,
// a run-length reference model feeds an expected-value queue checked each cycle.
module tb_iq_gen_hls_deadlock_param_monitor;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] axis;
    logic [1:0] sub;
    logic [1:0] idle;
    logic       clr;

    always #5 clock = ~clock;

    iq_gen_hls_deadlock_param_monitor_if #(.NUM_AXIS(4), .NUM_SUB(2), .CNT_W(4))  if0 ();
    iq_gen_hls_deadlock_param_monitor_if #(.NUM_AXIS(4), .NUM_SUB(2), .CNT_W(32)) if1 ();
    iq_gen_hls_deadlock_param_monitor_if #(.NUM_AXIS(4), .NUM_SUB(2), .CNT_W(8))  if2 ();

    assign if0.axis_block_sigs = axis;
    assign if0.sub_block_sigs  = sub;
    assign if0.inst_idle_sigs  = idle;
    assign if0.clear           = clr;
    assign if1.axis_block_sigs = axis;
    assign if1.sub_block_sigs  = sub;
    assign if1.inst_idle_sigs  = idle;
    assign if1.clear           = clr;
    assign if2.axis_block_sigs = axis;
    assign if2.sub_block_sigs  = sub;
    assign if2.inst_idle_sigs  = idle;
    assign if2.clear           = clr;

    iq_gen_hls_deadlock_param_monitor #(.NUM_AXIS(4), .NUM_SUB(2), .HOLD_CYCLES(4), .CNT_W(4), .STICKY(0))
        dut0 (.clock(clock), .reset(reset), .mon(if0.slave));
    iq_gen_hls_deadlock_param_monitor #(.NUM_AXIS(4), .NUM_SUB(2), .HOLD_CYCLES(4), .CNT_W(32), .STICKY(1))
        dut1 (.clock(clock), .reset(reset), .mon(if1.slave));
    iq_gen_hls_deadlock_param_monitor #(.NUM_AXIS(4), .NUM_SUB(2), .HOLD_CYCLES(1), .CNT_W(8), .STICKY(0))
        dut2 (.clock(clock), .reset(reset), .mon(if2.slave));

    logic [2:0]       obs_blk;
    logic [2:0][3:0]  obs_info;
    logic [2:0][2:0]  obs_fidx;
    logic [2:0][31:0] obs_cyc;
    logic [2:0][7:0]  obs_ev;

    assign obs_blk[0]  = if0.block;
    assign obs_blk[1]  = if1.block;
    assign obs_blk[2]  = if2.block;
    assign obs_info[0] = if0.axis_block_info;
    assign obs_info[1] = if1.axis_block_info;
    assign obs_info[2] = if2.axis_block_info;
    assign obs_fidx[0] = if0.first_block_idx;
    assign obs_fidx[1] = if1.first_block_idx;
    assign obs_fidx[2] = if2.first_block_idx;
    assign obs_cyc[0]  = {28'd0, if0.block_cycles};
    assign obs_cyc[1]  = if1.block_cycles;
    assign obs_cyc[2]  = {24'd0, if2.block_cycles};
    assign obs_ev[0]   = if0.block_events;
    assign obs_ev[1]   = if1.block_events;
    assign obs_ev[2]   = if2.block_events;

    int hold_t   [3] = '{4, 4, 1};
    int sticky_t [3] = '{0, 1, 0};
    int cntw_t   [3] = '{4, 32, 8};

    int          run_m  [3];
    logic        blk_m  [3];
    logic [3:0]  info_m [3];
    logic [2:0]  fidx_m [3];
    logic [31:0] cyc_m  [3];
    logic [7:0]  ev_m   [3];

    typedef struct {
        int          d;
        logic        blk;
        logic [3:0]  info;
        logic [2:0]  fidx;
        logic [31:0] cyc;
        logic [7:0]  ev;
    } exp_t;

    exp_t sbq[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [2:0] first_set(input logic [3:0] a);
        for (int k = 0; k < 4; k++) if (a[k]) return 3'(k);
        return 3'd4;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            run_m[d] = 0; blk_m[d] = 1'b0; info_m[d] = '0;
            fidx_m[d] = '0; cyc_m[d] = '0; ev_m[d] = '0;
        end
        sbq.delete();
    endtask

    // block(n+1) is high when raw has been high for HOLD consecutive cycles since
    // the last clear (or, sticky, at any point since the last clear).
    task automatic model_push();
        logic        raw, q, bn, en;
        int          rn;
        logic [32:0] wide;
        logic [31:0] cmax;
        exp_t        e;
        raw = (|axis) || (|(sub & ~idle));
        for (int d = 0; d < 3; d++) begin
            wide = (33'd1 << cntw_t[d]) - 33'd1;
            cmax = wide[31:0];
            rn = clr ? 0 : (raw ? ((run_m[d] < 100000) ? run_m[d] + 1 : run_m[d]) : 0);
            q  = (rn >= hold_t[d]);
            bn = clr ? 1'b0 : ((sticky_t[d] != 0) ? (blk_m[d] | q) : q);
            en = bn && !blk_m[d];
            if (!bn)                            info_m[d] = '0;
            else if (en || sticky_t[d] == 0)    info_m[d] = axis;
            else                                info_m[d] = info_m[d] | axis;
            if (clr)     fidx_m[d] = '0;
            else if (en) fidx_m[d] = first_set(axis);
            if (clr)                              cyc_m[d] = '0;
            else if (blk_m[d] && cyc_m[d] != cmax) cyc_m[d] = cyc_m[d] + 32'd1;
            if (clr)                         ev_m[d] = '0;
            else if (en && ev_m[d] != 8'hFF) ev_m[d] = ev_m[d] + 8'd1;
            run_m[d] = rn;
            blk_m[d] = bn;
            e.d = d; e.blk = bn; e.info = info_m[d]; e.fidx = fidx_m[d];
            e.cyc = cyc_m[d]; e.ev = ev_m[d];
            sbq.push_back(e);
        end
    endtask

    task automatic compare();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("d%0d.block", e.d),  32'(obs_blk[e.d]),  32'(e.blk));
            chk($sformatf("d%0d.info", e.d),   32'(obs_info[e.d]), 32'(e.info));
            chk($sformatf("d%0d.fidx", e.d),   32'(obs_fidx[e.d]), 32'(e.fidx));
            chk($sformatf("d%0d.cycles", e.d), obs_cyc[e.d],       e.cyc);
            chk($sformatf("d%0d.events", e.d), 32'(obs_ev[e.d]),   32'(e.ev));
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [1:0] s, input logic [1:0] i, input logic c);
        axis = a; sub = s; idle = i; clr = c;
        model_push();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.d%0d.block", tag, d),  32'(obs_blk[d]),  32'd0);
            chk($sformatf("%s.d%0d.info", tag, d),   32'(obs_info[d]), 32'd0);
            chk($sformatf("%s.d%0d.fidx", tag, d),   32'(obs_fidx[d]), 32'd0);
            chk($sformatf("%s.d%0d.cycles", tag, d), obs_cyc[d],       32'd0);
            chk($sformatf("%s.d%0d.events", tag, d), 32'(obs_ev[d]),   32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a;
        logic [1:0] s, i;
        reset = 1'b1; axis = '0; sub = '0; idle = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk_all_zero("reset");
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;

        repeat (3) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // short burst never qualifies on HOLD=4
        repeat (3) step(4'b0100, 2'b00, 2'b00, 1'b0);
        repeat (3) step(4'b0000, 2'b00, 2'b00, 1'b0);
        chk("short.d0.events", 32'(obs_ev[0]), 32'd0);

        // main latency / bitmap / first index
        repeat (9) step(4'b0110, 2'b00, 2'b00, 1'b0);
        chk("hold.d0.block", 32'(obs_blk[0]),  32'd1);
        chk("hold.d0.fidx",  32'(obs_fidx[0]), 32'd1);
        chk("hold.d0.info",  32'(obs_info[0]), 32'h6);
        chk("hold.d0.cyc",   obs_cyc[0],       32'd5);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // child-only cause
        repeat (6) step(4'b0000, 2'b01, 2'b01, 1'b0);
        chk("child_idle.d0.block", 32'(obs_blk[0]), 32'd0);
        repeat (5) step(4'b0000, 2'b01, 2'b00, 1'b0);
        chk("child.d0.block", 32'(obs_blk[0]),  32'd1);
        chk("child.d0.fidx",  32'(obs_fidx[0]), 32'd4);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // sticky accumulation and clear
        step(4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (6) step(4'b0001, 2'b00, 2'b00, 1'b0);
        repeat (2) step(4'b1001, 2'b00, 2'b00, 1'b0);
        repeat (3) step(4'b0000, 2'b00, 2'b00, 1'b0);
        chk("sticky.d1.block", 32'(obs_blk[1]),  32'd1);
        chk("sticky.d1.info",  32'(obs_info[1]), 32'h9);
        step(4'b0000, 2'b00, 2'b00, 1'b1);
        chk("sticky_clr.d1.block",  32'(obs_blk[1]), 32'd0);
        chk("sticky_clr.d1.cycles", obs_cyc[1],       32'd0);
        chk("sticky_clr.d1.events", 32'(obs_ev[1]),  32'd0);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // clear on the would-be entry cycle
        repeat (3) step(4'b0001, 2'b00, 2'b00, 1'b0);
        step(4'b0001, 2'b00, 2'b00, 1'b1);
        chk("clr_entry.d0.block",  32'(obs_blk[0]), 32'd0);
        chk("clr_entry.d0.events", 32'(obs_ev[0]),  32'd0);
        repeat (3) step(4'b0001, 2'b00, 2'b00, 1'b0);
        chk("requal.d0.block_early", 32'(obs_blk[0]), 32'd0);
        step(4'b0001, 2'b00, 2'b00, 1'b0);
        chk("requal.d0.block", 32'(obs_blk[0]), 32'd1);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // block_cycles saturation on the 4-bit counter
        step(4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (20) step(4'b0010, 2'b00, 2'b00, 1'b0);
        chk("sat.d0.cycles", obs_cyc[0], 32'd15);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // single-cycle glitch restarts qualification
        repeat (3) step(4'b1000, 2'b00, 2'b00, 1'b0);
        step(4'b0000, 2'b00, 2'b00, 1'b0);
        repeat (3) step(4'b1000, 2'b00, 2'b00, 1'b0);
        chk("glitch.d0.block_early", 32'(obs_blk[0]), 32'd0);
        step(4'b1000, 2'b00, 2'b00, 1'b0);
        chk("glitch.d0.block", 32'(obs_blk[0]), 32'd1);
        repeat (2) step(4'b0000, 2'b00, 2'b00, 1'b0);

        // 300 separate qualifying episodes
        for (int n = 0; n < 300; n++) begin
            a = 4'($urandom_range(1, 15));
            s = 2'($urandom_range(0, 3));
            i = 2'($urandom_range(0, 3));
            repeat ($urandom_range(4, 6)) step(a, s, i, 1'b0);
            step(4'b0000, 2'b00, 2'b00, 1'b0);
        end
        chk("events_sat.d0", 32'(obs_ev[0]), 32'd255);

        // random segments with occasional clear
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            s = 2'($urandom_range(0, 3));
            i = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 8)) step(a, s, i, 1'b0);
            if ($urandom_range(0, 9) == 0) step(a, s, i, 1'b1);
        end

        // asynchronous reset in the middle of a block
        step(4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (6) step(4'b0100, 2'b00, 2'b00, 1'b0);
        chk("pre_rst.d0.block", 32'(obs_blk[0]), 32'd1);
        #2;
        reset = 1'b1;
        axis = '0; sub = '0; idle = '0; clr = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clock);
        @(posedge clock);
        @(negedge clock) reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        repeat (3) step(4'b0000, 2'b00, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
